i2c_cmd_ctrl: RTL and testbench

Sequences the OLED I2C bus on behalf of the instruction decoder. It accepts one bus command at a time (START, WRITE byte, STOP) over a valid/ready handshake, drives open-drain SCL/SDA with quarter-period timing, samples the slave ACK, and reports completion. It sits between the decoder/core control path and the board's I2C pins.

---
 rtl/i2c_cmd_ctrl_if.sv | 22 ++
 rtl/i2c_cmd_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_cmd_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_ctrl_if.sv
// Command handshake between the instruction decoder (master) and i2c_cmd_ctrl (slave).
// Keeps the controller's documented pin names so both sides read the same way.
interface i2c_cmd_ctrl_if;
    logic       i_cmd_valid;
    logic [1:0] i_cmd;
    logic [7:0] i_data;
    logic       o_cmd_ready;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic       o_nack;

    modport master (
        output i_cmd_valid, i_cmd, i_data,
        input  o_cmd_ready, o_busy, o_done, o_err, o_nack
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_data,
        output o_cmd_ready, o_busy, o_done, o_err, o_nack
    );
endinterface

// File: rtl/i2c_cmd_ctrl.sv
// Sequences START / WRITE / STOP on an open-drain I2C bus with quarter-period SCL timing.
// Optional slave clock stretching is compiled in with I2C_CLK_STRETCH_EN.
module i2c_cmd_ctrl #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic          i_clk,
    input  logic          i_rst,
    i2c_cmd_ctrl_if.slave cmd,
    output logic          o_scl,
    output logic          o_sda_oe,
    input  logic          i_sda,
    input  logic          i_scl
);
    localparam int unsigned    CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_WRITE, ST_ACK, ST_STOP, ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             held_q, held_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic             nack_q, nack_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
    logic             sda_s1_q, sda_s2_q;

    logic busy, accept, advance, quarter_end, phase_end;

    assign busy        = (state_q == ST_START) || (state_q == ST_WRITE) ||
                         (state_q == ST_ACK)   || (state_q == ST_STOP);
    assign accept      = cmd.i_cmd_valid && !busy;
    assign quarter_end = (cnt_q == CNT_LAST);
    assign phase_end   = quarter_end && (qtr_q == 2'd3);

`ifdef I2C_CLK_STRETCH_EN
    logic scl_s1_q, scl_s2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= i_scl;
            scl_s2_q <= scl_s1_q;
        end
    end

    // A slave holding SCL low freezes the count at the start of the high quarters.
    assign advance = !(((qtr_q == 2'd1) || (qtr_q == 2'd2)) && (cnt_q == '0) && !scl_s2_q);
`else
    logic unused_scl;
    assign unused_scl = i_scl;
    assign advance    = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            qtr_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            held_q   <= 1'b0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            held_q   <= held_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
            sda_s1_q <= i_sda;
            sda_s2_q <= sda_s1_q;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        data_d   = data_q;
        held_d   = held_q;
        err_d    = err_q;
        ack_d    = ack_q;
        nack_d   = nack_q;
        scl_d    = scl_q;
        sda_oe_d = sda_oe_q;

        if (accept) begin
            cnt_d  = '0;
            qtr_d  = '0;
            bit_d  = '0;
            data_d = cmd.i_data;
            err_d  = 1'b0;
            case (cmd_e'(cmd.i_cmd))
                CMD_START: state_d = ST_START;
                CMD_WRITE: begin
                    state_d = held_q ? ST_WRITE : ST_DONE;
                    err_d   = !held_q;
                end
                CMD_STOP: begin
                    state_d = held_q ? ST_STOP : ST_DONE;
                    err_d   = !held_q;
                end
                default: begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            endcase
        end else if (busy) begin
            if (advance) begin
                if (quarter_end) begin
                    cnt_d = '0;
                    qtr_d = qtr_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((state_q == ST_ACK) && (qtr_q == 2'd2) && quarter_end) begin
                    ack_d = sda_s2_q;
                end
                if (phase_end) begin
                    case (state_q)
                        ST_START: begin
                            state_d = ST_DONE;
                            held_d  = 1'b1;
                        end
                        ST_WRITE: begin
                            data_d = {data_q[6:0], 1'b0};
                            bit_d  = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_d = ST_ACK;
                            end
                        end
                        ST_ACK: begin
                            state_d = ST_DONE;
                            nack_d  = ack_q;
                        end
                        ST_STOP: begin
                            state_d = ST_DONE;
                            held_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end

        // Pin levels follow the next state so the registered lines switch with the quarter.
        case (state_d)
            ST_START: begin
                case (qtr_d)
                    2'd0: sda_oe_d = 1'b0;
                    2'd1: begin
                        scl_d    = 1'b1;
                        sda_oe_d = 1'b0;
                    end
                    2'd2: begin
                        scl_d    = 1'b1;
                        sda_oe_d = 1'b1;
                    end
                    default: begin
                        scl_d    = 1'b0;
                        sda_oe_d = 1'b1;
                    end
                endcase
            end
            ST_WRITE: begin
                scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_oe_d = !data_d[7];
            end
            ST_ACK: begin
                scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_oe_d = 1'b0;
            end
            ST_STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = (qtr_d < 2'd2);
            end
            default: ;
        endcase
    end

    assign cmd.o_cmd_ready = !busy;
    assign cmd.o_busy      = busy;
    assign cmd.o_done      = (state_q == ST_DONE);
    assign cmd.o_err       = (state_q == ST_DONE) && err_q;
    assign cmd.o_nack      = nack_q;
    assign o_scl           = scl_q;
    assign o_sda_oe        = sda_oe_q;
endmodule

// File: tb/tb_i2c_cmd_ctrl.sv
// Self-checking bench for i2c_cmd_ctrl: vector table, hand sequences and random commands
// checked against a quarter-level line model of the bus.
module tb_i2c_cmd_ctrl;
    localparam int D      = 4;
    localparam int BUDGET = 40 * D + 8;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_STOP  = 2'b10;
    localparam logic [1:0] C_RSVD  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_o, sda_oe;
    logic slave_low   = 1'b0;
    logic stretch_low = 1'b0;
    logic sda_pin, scl_pin;

    int n_checks = 0;
    int n_pass   = 0;

    i2c_cmd_ctrl_if cmd_if ();

    assign sda_pin = !(sda_oe || slave_low);
    assign scl_pin = scl_o && !stretch_low;

    i2c_cmd_ctrl #(.CLK_DIV(D)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .cmd     (cmd_if),
        .o_scl   (scl_o),
        .o_sda_oe(sda_oe),
        .i_sda   (sda_pin),
        .i_scl   (scl_pin)
    );

    always #5 clk = ~clk;

    // Reference model: bus-held flag, last ACK result, current line levels and
    // the expected {scl, sda_oe} level for every clock of the running command.
    logic       m_held, m_nack, m_scl, m_oe;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        bit         ack_low;
        int         exp_lat;
        logic       exp_err;
        logic       exp_nack;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_quarter(input logic scl, input logic oe);
        for (int i = 0; i < D; i++) exp_q.push_back({scl, oe});
    endtask

    task automatic model_reset();
        m_held = 1'b0;
        m_nack = 1'b0;
        m_scl  = 1'b1;
        m_oe   = 1'b0;
    endtask

    task automatic model_cmd(input logic [1:0] c, input logic [7:0] d, input bit ack_low,
                             output logic err);
        logic b;
        exp_q.delete();
        err = 1'b0;
        if (c == C_START) begin
            push_quarter(m_scl, 1'b0);
            push_quarter(1'b1, 1'b0);
            push_quarter(1'b1, 1'b1);
            push_quarter(1'b0, 1'b1);
            m_held = 1'b1;
        end else if (c == C_WRITE && m_held) begin
            for (int i = 7; i >= 0; i--) begin
                b = d[i];
                push_quarter(1'b0, !b);
                push_quarter(1'b1, !b);
                push_quarter(1'b1, !b);
                push_quarter(1'b0, !b);
            end
            push_quarter(1'b0, 1'b0);
            push_quarter(1'b1, 1'b0);
            push_quarter(1'b1, 1'b0);
            push_quarter(1'b0, 1'b0);
            m_nack = !ack_low;
        end else if (c == C_STOP && m_held) begin
            push_quarter(1'b0, 1'b1);
            push_quarter(1'b1, 1'b1);
            push_quarter(1'b1, 1'b0);
            push_quarter(1'b1, 1'b0);
            m_held = 1'b0;
        end else begin
            err = 1'b1;
        end
        if (exp_q.size() > 0) {m_scl, m_oe} = exp_q[exp_q.size() - 1];
    endtask

    // Called #1 after a clock edge with the DUT ready; returns at #1 after the o_done edge.
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input bit ack_low,
                           input bit chain, input logic [1:0] next_c,
                           output int lat, output logic err, output logic nack);
        logic e_err;
        int   mism, bad_hs;
        model_cmd(c, d, ack_low, e_err);
        check("ready_before_cmd", 32'(cmd_if.o_cmd_ready), 32'd1);
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd       = c;
        cmd_if.i_data      = d;
        lat    = 0;
        mism   = 0;
        bad_hs = 0;
        for (int k = 1; k <= BUDGET && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                if (chain) begin
                    cmd_if.i_cmd  = next_c;
                    cmd_if.i_data = 8'($urandom);
                end else begin
                    cmd_if.i_cmd_valid = 1'b0;
                    cmd_if.i_cmd       = ~c;
                    cmd_if.i_data      = ~d;
                end
            end
            slave_low = ack_low && (c == C_WRITE) && (k > 32 * D);
            if (cmd_if.o_done) begin
                lat = k;
            end else begin
                if (k > exp_q.size() || {scl_o, sda_oe} != exp_q[k-1]) mism++;
                if (!cmd_if.o_busy || cmd_if.o_cmd_ready) bad_hs++;
            end
        end
        slave_low = 1'b0;
        err  = cmd_if.o_err;
        nack = cmd_if.o_nack;
        check("latency", 32'(lat), 32'(exp_q.size() + 1));
        check("line_trace_mismatches", 32'(mism), 32'd0);
        check("busy_ready_while_active", 32'(bad_hs), 32'd0);
        check("err_at_done", 32'(cmd_if.o_err), 32'(e_err));
        check("nack_at_done", 32'(cmd_if.o_nack), 32'(m_nack));
        check("busy_at_done", 32'(cmd_if.o_busy), 32'd0);
        check("ready_at_done", 32'(cmd_if.o_cmd_ready), 32'd1);
        check("lines_at_done", 32'({scl_o, sda_oe}), 32'({m_scl, m_oe}));
    endtask

    initial begin
        int   lat, dones;
        logic err, nack;
        logic [1:0] rc;

        vecs[0]  = '{C_WRITE, 8'h11, 1'b1, 1,   1'b1, 1'b0};
        vecs[1]  = '{C_STOP,  8'h00, 1'b0, 1,   1'b1, 1'b0};
        vecs[2]  = '{C_RSVD,  8'h00, 1'b0, 1,   1'b1, 1'b0};
        vecs[3]  = '{C_START, 8'h00, 1'b0, 17,  1'b0, 1'b0};
        vecs[4]  = '{C_WRITE, 8'h3C, 1'b1, 145, 1'b0, 1'b0};
        vecs[5]  = '{C_WRITE, 8'hA5, 1'b0, 145, 1'b0, 1'b1};
        vecs[6]  = '{C_STOP,  8'h00, 1'b0, 17,  1'b0, 1'b1};
        vecs[7]  = '{C_START, 8'h00, 1'b0, 17,  1'b0, 1'b1};
        vecs[8]  = '{C_RSVD,  8'hFF, 1'b0, 1,   1'b1, 1'b1};
        vecs[9]  = '{C_WRITE, 8'h55, 1'b1, 145, 1'b0, 1'b0};
        vecs[10] = '{C_START, 8'h00, 1'b0, 17,  1'b0, 1'b0};
        vecs[11] = '{C_STOP,  8'h00, 1'b0, 17,  1'b0, 1'b0};
        vecs[12] = '{C_STOP,  8'h00, 1'b0, 1,   1'b1, 1'b0};

        cmd_if.i_cmd_valid = 1'b0;
        cmd_if.i_cmd       = 2'b00;
        cmd_if.i_data      = 8'h00;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_scl", 32'(scl_o), 32'd1);
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_ready", 32'(cmd_if.o_cmd_ready), 32'd1);
        check("reset_busy", 32'(cmd_if.o_busy), 32'd0);
        check("reset_done", 32'(cmd_if.o_done), 32'd0);
        check("reset_err", 32'(cmd_if.o_err), 32'd0);
        check("reset_nack", 32'(cmd_if.o_nack), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef I2C_CLK_STRETCH_EN
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd       = C_START;
        lat = 0;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) cmd_if.i_cmd_valid = 1'b0;
            stretch_low = (k >= 3) && (k <= 22);
            if (cmd_if.o_done) lat = k;
        end
        stretch_low = 1'b0;
        check("stretch_latency", 32'(lat), 32'(4 * D + 1 + 20));
`else
        // Vector table: hand-derived latency, error and ACK result for each command.
        foreach (vecs[i]) begin
            run_cmd(vecs[i].cmd, vecs[i].data, vecs[i].ack_low, 1'b0, 2'b00, lat, err, nack);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_nack", i), 32'(nack), 32'(vecs[i].exp_nack));
        end

        // Valid held high across a START: the STOP behind it is taken on the o_done cycle.
        run_cmd(C_START, 8'h00, 1'b0, 1'b1, C_STOP, lat, err, nack);
        run_cmd(C_STOP, 8'h00, 1'b0, 1'b0, 2'b00, lat, err, nack);
        check("chained_stop_latency", 32'(lat), 32'(4 * D + 1));
        check("stop_released_lines", 32'({scl_o, sda_oe}), 32'b10);

        // Reset in the middle of a WRITE aborts it with no completion.
        run_cmd(C_START, 8'h00, 1'b0, 1'b0, 2'b00, lat, err, nack);
        cmd_if.i_cmd_valid = 1'b1;
        cmd_if.i_cmd       = C_WRITE;
        cmd_if.i_data      = 8'hC3;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) cmd_if.i_cmd_valid = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_scl", 32'(scl_o), 32'd1);
        check("abort_sda_oe", 32'(sda_oe), 32'd0);
        check("abort_busy", 32'(cmd_if.o_busy), 32'd0);
        check("abort_done", 32'(cmd_if.o_done), 32'd0);
        rst = 1'b0;
        model_reset();
        dones = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (cmd_if.o_done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_cmd(C_WRITE, 8'h81, 1'b1, 1'b0, 2'b00, lat, err, nack);
        check("write_after_abort_err", 32'(err), 32'd1);

        // Random commands against the line model.
        for (int n = 0; n < 24; n++) begin
            rc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) :
                 (m_held ? 2'($urandom_range(0, 2)) : C_START);
            run_cmd(rc, 8'($urandom), 1'($urandom), 1'b0, 2'b00, lat, err, nack);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
